// File: rtl/key_pkg.sv
// Shared key-input definitions: debouncer FSM encoding and default timing constants
// used by the debouncer and the downstream 100 Hz edge detectors.
package key_pkg;

    localparam int KEY_STABLE_TICKS_DEF = 3;
    localparam int KEY_LONG_TICKS_DEF   = 100;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    typedef enum logic [1:0] {
        IDLE        = ST_IDLE,
        PRESS_CHK   = ST_PRESS_CHK,
        PRESSED     = ST_PRESSED,
        RELEASE_CHK = ST_RELEASE_CHK
    } key_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; RST_VAL selects the idle level
// both stages take on synchronous reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q1_d, q1_q;
    logic q2_d, q2_q;

    always_comb begin
        q1_d = d;
        q2_d = q1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q <= RST_VAL;
            q2_q <= RST_VAL;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/key_debounce_100hz.sv
// Single-key debouncer on the 100 Hz tick: 2-flop sync, polarity fix, 4-state filter.
// Optional hold-to-act pulse on long_press when KEY_LONG_PRESS_EN is defined.
module key_debounce_100hz
    import key_pkg::*;
#(
    parameter int STABLE_TICKS   = KEY_STABLE_TICKS_DEF,
    parameter int KEY_ACTIVE_LOW = 1
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_TICKS     = KEY_LONG_TICKS_DEF
`endif
) (
    input  logic clk_100Hz,
    input  logic rst,
    input  logic key_raw,
`ifdef KEY_LONG_PRESS_EN
    output logic long_press,
`endif
    output logic key_out
);

    localparam logic          POL      = (KEY_ACTIVE_LOW != 0);
    localparam int            CW       = $clog2(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic       q2;
    logic       k_s;
    key_state_t state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic       key_out_d, key_out_q;

    // Reset value is the released raw level, so k_s comes out of reset as 0.
    sync_2ff #(.RST_VAL(POL)) u_sync (
        .clk (clk_100Hz),
        .rst (rst),
        .d   (key_raw),
        .q   (q2)
    );

    assign k_s = q2 ^ POL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (k_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_CHK: begin
                if (!k_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!k_s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_CHK: begin
                if (k_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        key_out_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    end

    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_out_q <= key_out_d;
        end
    end

    assign key_out = key_out_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int            HW       = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hold_d, hold_q;
    logic          long_press_d, long_press_q;

    // A bounce back from RELEASE_CHK keeps the count; only a fresh press restarts it.
    always_comb begin
        hold_d = hold_q;
        if (state_d == IDLE || state_q == PRESS_CHK)
            hold_d = '0;
        else if (state_q == PRESSED && hold_q != HOLD_MAX)
            hold_d = hold_q + HW'(1);
        long_press_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
    end

    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            hold_q       <= '0;
            long_press_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`endif

endmodule

// File: tb/tb_key_debounce_100hz.sv
// Bench for key_debounce_100hz: default active-low instance plus a STABLE_TICKS=2
// active-high instance, checked per edge against a run-length reference model.
module tb_key_debounce_100hz;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, raw_a, raw_b;
    logic out_a, out_b;
`ifdef KEY_LONG_PRESS_EN
    logic lp_a, lp_b;
`endif

    key_debounce_100hz u_a (
        .clk_100Hz  (clk),
        .rst        (rst),
        .key_raw    (raw_a),
`ifdef KEY_LONG_PRESS_EN
        .long_press (lp_a),
`endif
        .key_out    (out_a)
    );

    key_debounce_100hz #(.STABLE_TICKS(2), .KEY_ACTIVE_LOW(0)) u_b (
        .clk_100Hz  (clk),
        .rst        (rst),
        .key_raw    (raw_b),
`ifdef KEY_LONG_PRESS_EN
        .long_press (lp_b),
`endif
        .key_out    (out_b)
    );

    typedef struct {
        logic  r;
        logic  a;
        logic  b;
        string tag;
    } stim_t;

    typedef struct {
        string tag;
        logic  a;
        logic  b;
        logic  lpa;
        logic  lpb;
    } exp_t;

    stim_t stim[$];
    exp_t  sb[$];
    int    checks = 0;
    int    fails  = 0;

    // Reference: synchroniser pipe plus a run-length of samples disagreeing with the output.
    logic m_q1[2], m_q2[2], m_out[2], m_lp[2];
    int   m_run[2], m_hold[2];

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%b exp=%b", tag, act, exp);
        end
    endtask

    task automatic add(input int n, input logic r, input logic a, input logic b, input string tag);
        stim_t s;
        s.r = r; s.a = a; s.b = b; s.tag = tag;
        for (int i = 0; i < n; i++) stim.push_back(s);
    endtask

    task automatic model_step(input int i, input logic raw, input logic r);
        int   st;
        logic pol, ks, was_pc, was_pr;
        int   old_hold;
        st  = (i == 0) ? 3 : 2;
        pol = (i == 0);
        if (r) begin
            m_q1[i] = pol; m_q2[i] = pol; m_out[i] = 1'b0;
            m_run[i] = 0; m_hold[i] = 0; m_lp[i] = 1'b0;
        end else begin
            ks     = m_q2[i] ^ pol;
            was_pc = !m_out[i] && m_run[i] > 0;
            was_pr = m_out[i] && m_run[i] == 0;
            if (ks != m_out[i]) m_run[i]++;
            else                m_run[i] = 0;
            if (m_run[i] >= st) begin
                m_out[i] = ~m_out[i];
                m_run[i] = 0;
            end
            old_hold = m_hold[i];
            if (!m_out[i] || was_pc)         m_hold[i] = 0;
            else if (was_pr && m_hold[i] < 100) m_hold[i]++;
            m_lp[i] = (m_hold[i] == 100) && (old_hold != 100);
            m_q2[i] = m_q1[i];
            m_q1[i] = raw;
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; raw_a = 1'b1; raw_b = 1'b0;

        add(2,   1, 1, 0, "reset");
        add(4,   0, 1, 0, "idle");
        add(10,  0, 0, 0, "press");
        add(20,  0, 0, 0, "hold");
        add(1,   0, 1, 0, "rel_glitch");
        add(19,  0, 0, 0, "hold2");
        add(10,  0, 1, 0, "release");
        add(2,   0, 0, 0, "bounce_lo");
        add(1,   0, 1, 0, "bounce_hi");
        add(10,  0, 0, 0, "bounce_press");
        add(10,  0, 1, 0, "release2");
        add(1,   0, 1, 1, "b_pulse");
        add(6,   0, 1, 0, "b_quiet");
        add(8,   0, 1, 1, "b_press");
        add(6,   0, 1, 0, "b_release");
        add(4,   0, 0, 0, "press_chk");
        add(1,   1, 0, 0, "rst_mid");
        add(150, 0, 0, 0, "long");
        add(10,  0, 1, 0, "release3");

        foreach (stim[n]) begin
            rst   = stim[n].r;
            raw_a = stim[n].a;
            raw_b = stim[n].b;
            model_step(0, stim[n].a, stim[n].r);
            model_step(1, stim[n].b, stim[n].r);
            e.tag = stim[n].tag;
            e.a   = m_out[0];
            e.b   = m_out[1];
            e.lpa = m_lp[0];
            e.lpb = m_lp[1];
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.tag, "_a"}, out_a, e.a);
            chk({e.tag, "_b"}, out_b, e.b);
`ifdef KEY_LONG_PRESS_EN
            chk({e.tag, "_lp_a"}, lp_a, e.lpa);
            chk({e.tag, "_lp_b"}, lp_b, e.lpb);
`endif
        end

        chk("sb_drained", (sb.size() == 0), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
